counter_disp_core: RTL

Sequential core of the n-bit counter user project. It samples three pad inputs, runs a prescaled 16-bit up/down counter, and drives a time-multiplexed 4-digit hex seven-segment display plus two status pins. It produces the `io_out` vector whose upper 14 bits the pad output-enable tie-off block marks as outputs; `io_in[2:0]` are its inputs.

---
 rtl/counter_disp_core_pkg.sv | 38 +++
 rtl/counter_disp_core_hex_to_7seg.sv | 36 +++
 rtl/counter_disp_core.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/counter_disp_core_pkg.sv
// counter_disp_core_pkg
// Shared constants for the n-bit counter user project:
//   - pad index constants for io_in / io_out
//   - seven-segment glyphs 0-F (bit 0 = segment a ... bit 6 = segment g,
//     active-high)
package counter_disp_core_pkg;

  // io_in pad indices
  localparam int IN_EN    = 0;
  localparam int IN_UP_DN = 1;
  localparam int IN_CLR   = 2;

  // io_out pad indices
  localparam int OUT_SEG_LSB = 3;   // seg[6:0] on io_out[9:3]
  localparam int OUT_DP      = 10;
  localparam int OUT_DIG_LSB = 11;  // dig[3:0] on io_out[14:11]
  localparam int OUT_WRAP    = 15;
  localparam int OUT_HB      = 16;

  // Glyphs, segment order gfedcba
  localparam logic [6:0] GLYPH_0 = 7'b0111111;
  localparam logic [6:0] GLYPH_1 = 7'b0000110;
  localparam logic [6:0] GLYPH_2 = 7'b1011011;
  localparam logic [6:0] GLYPH_3 = 7'b1001111;
  localparam logic [6:0] GLYPH_4 = 7'b1100110;
  localparam logic [6:0] GLYPH_5 = 7'b1101101;
  localparam logic [6:0] GLYPH_6 = 7'b1111101;
  localparam logic [6:0] GLYPH_7 = 7'b0000111;
  localparam logic [6:0] GLYPH_8 = 7'b1111111;
  localparam logic [6:0] GLYPH_9 = 7'b1101111;
  localparam logic [6:0] GLYPH_A = 7'b1110111;
  localparam logic [6:0] GLYPH_B = 7'b1111100;
  localparam logic [6:0] GLYPH_C = 7'b0111001;
  localparam logic [6:0] GLYPH_D = 7'b1011110;
  localparam logic [6:0] GLYPH_E = 7'b1111001;
  localparam logic [6:0] GLYPH_F = 7'b1110001;

endpackage

// File: rtl/counter_disp_core_hex_to_7seg.sv
// hex_to_7seg
// Combinational nibble to seven-segment glyph lookup (hex 0-F).
// Ports:
//   nibble  in  4  value to display
//   seg     out 7  segments gfedcba, active-high
module hex_to_7seg
  import counter_disp_core_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = GLYPH_0;
    case (nibble)
      4'h0: seg = GLYPH_0;
      4'h1: seg = GLYPH_1;
      4'h2: seg = GLYPH_2;
      4'h3: seg = GLYPH_3;
      4'h4: seg = GLYPH_4;
      4'h5: seg = GLYPH_5;
      4'h6: seg = GLYPH_6;
      4'h7: seg = GLYPH_7;
      4'h8: seg = GLYPH_8;
      4'h9: seg = GLYPH_9;
      4'hA: seg = GLYPH_A;
      4'hB: seg = GLYPH_B;
      4'hC: seg = GLYPH_C;
      4'hD: seg = GLYPH_D;
      4'hE: seg = GLYPH_E;
      4'hF: seg = GLYPH_F;
      default: seg = GLYPH_0;
    endcase
  end

endmodule

// File: rtl/counter_disp_core.sv
// counter_disp_core
// Sequential core of the n-bit counter user project: synchronizes three
// pad inputs, runs a prescaled 16-bit up/down counter with sticky wrap flag
// and heartbeat, and scans the count onto a 4-digit hex seven-segment display.
// Ports:
//   vccd1, vssd1  inout  power pins (USE_POWER_PINS only)
//   wb_clk_i      in     clock
//   wb_rst_i      in     asynchronous active-high reset
//   io_in         in     [0] en, [1] up_dn (1 = up), [2] clr, rest ignored
//   io_out        out    [2:0] 0, [9:3] seg, [10] dp, [14:11] dig (one-hot),
//                        [15] wrap, [16] hb
module counter_disp_core
  import counter_disp_core_pkg::*;
#(
  parameter int NUM_INS  = 3,
  parameter int NUM_OUTS = 14,
  parameter int NUM_IOS  = 17,
  parameter int PRESCALE = 10_000_000,
  parameter int SCAN_DIV = 10_000
) (
`ifdef USE_POWER_PINS
  inout  wire                 vccd1,
  inout  wire                 vssd1,
`endif
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic [NUM_IOS-1:0]  io_in,
  output logic [NUM_IOS-1:0]  io_out
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST  = PW'(PRESCALE - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

  // Input synchronizers: stage 1 and stage 2 for {clr, up_dn, en}
  logic [NUM_INS-1:0] sync1;
  logic [NUM_INS-1:0] sync2;
  logic en_s, up_dn_s, clr_s;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= io_in[NUM_INS-1:0];
      sync2 <= sync1;
    end
  end

  assign en_s    = sync2[IN_EN];
  assign up_dn_s = sync2[IN_UP_DN];
  assign clr_s   = sync2[IN_CLR];

  // Pads above the input range carry nothing for this core.
  logic unused_io;
  assign unused_io = ^io_in[NUM_IOS-1:NUM_INS];

  // Prescaler: free-running, unaffected by en/clr so clr release keeps phase.
  logic [PW-1:0] pre_cnt;
  logic          tick;

  assign tick = (pre_cnt == PRE_LAST);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)  pre_cnt <= '0;
    else if (tick) pre_cnt <= '0;
    else           pre_cnt <= pre_cnt + 1'b1;
  end

  // Counter, sticky wrap flag and heartbeat
  logic [15:0] cnt;
  logic        wrap;
  logic        hb;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      cnt  <= '0;
      wrap <= 1'b0;
    end else if (clr_s) begin
      cnt  <= '0;
      wrap <= 1'b0;
    end else if (tick && en_s) begin
      if (up_dn_s) begin
        if (cnt == 16'hFFFF) wrap <= 1'b1;
        cnt <= cnt + 16'd1;
      end else begin
        if (cnt == 16'h0000) wrap <= 1'b1;
        cnt <= cnt - 16'd1;
      end
    end
  end

  // Heartbeat follows the prescaler only, so it proves the clock is alive
  // even while counting is disabled or held in clear.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)  hb <= 1'b0;
    else if (tick) hb <= ~hb;
  end

  // Display scan divider and digit index
  logic [SW-1:0] scan_cnt;
  logic [1:0]    idx;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      scan_cnt <= '0;
      idx      <= '0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
      idx      <= idx + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  // Single glyph decoder on the currently selected nibble
  logic [3:0] nibble;
  logic [6:0] seg_next;

  assign nibble = cnt[{idx, 2'b00} +: 4];

  hex_to_7seg u_hex_to_7seg (
    .nibble (nibble),
    .seg    (seg_next)
  );

  // seg, dp and dig load on the same edge so a digit never shows its
  // neighbour's glyph.
  logic [6:0] seg;
  logic       dp;
  logic [3:0] dig;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      seg <= GLYPH_0;
      dp  <= 1'b0;
      dig <= 4'b0001;
    end else begin
      seg <= seg_next;
      dp  <= (idx == 2'd0) && en_s;
      dig <= 4'b0001 << idx;
    end
  end

  always_comb begin
    io_out                                = '0;
    io_out[OUT_SEG_LSB +: 7]              = seg;
    io_out[OUT_DP]                        = dp;
    io_out[OUT_DIG_LSB +: 4]              = dig;
    io_out[OUT_WRAP]                      = wrap;
    io_out[OUT_HB]                        = hb;
  end

endmodule
